imm_operand_encoder: RTL
========================

Name: imm_operand_encoder

Overview:
- Streaming inverse of the decode-side immediate generator. Takes instruction fields plus a 32-bit immediate value and an immediate type, range-checks the immediate, and packs everything into a 32-bit RV32I instruction word.
- Used by the debug/instruction-injection path and the self-check stimulus generator to build instruction words for the pipeline.
- Two-stage pipeline with valid/ready handshakes on both sides, plus statistics counters.

Parameters:
- CNT_W, 16, width of the encoded-word and error counters.
- NOP_WORD, 32'h0000_0013, word emitted in place of any instruction that fails its check.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input fields are valid.
- in_ready  out  1  block accepts the input this cycle.
- in_type  in  3  immediate type: RTYPE=0, ITYPE=1, STYPE=2, BTYPE=3, UTYPE=4, JTYPE=5; 6 and 7 are illegal.
- in_imm  in  32  immediate value (byte offset for B and J).
- in_opcode  in  7  opcode field.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field, used only for RTYPE.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the output.
- out_instr  out  32  packed instruction.
- out_err  out  1  immediate out of range or illegal type; qualified by out_valid.
- enc_count  out  CNT_W  words delivered (out_valid & out_ready), saturating.
- err_count  out  CNT_W  delivered words with out_err=1, saturating.

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears:
  - S1 and S2 valid flags, so out_valid=0.
  - out_instr=0, out_err=0, enc_count=0, err_count=0.
  - in_ready=1 in the first cycle after release.
- Reset asserted mid-operation drops all in-flight words. No partial output is produced.
- Stage S1 captures the fields on in_valid & in_ready. It computes err and stores it with the fields.
- Range checks (err=1 when violated):
  - ITYPE, STYPE: in_imm[31:11] all equal.
  - BTYPE: in_imm[0]=0 and in_imm[31:12] all equal.
  - UTYPE: in_imm[11:0]=0.
  - JTYPE: in_imm[0]=0 and in_imm[31:20] all equal.
  - RTYPE: in_imm is ignored and never causes an error.
  - Types 6 and 7: always err.
- Stage S2 packs the word from the S1 register into the out_instr register, with op=in_opcode:
  - R: {funct7, rs2, rs1, funct3, rd, op}
  - I: {imm[11:0], rs1, funct3, rd, op}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
  - If err: out_instr=NOP_WORD and out_err=1; otherwise out_err=0.
- Latency: 2 cycles from the accepting edge to out_valid when out_ready stays high.
- Throughput: 1 word per cycle sustained.
- Flow control:
  - s2_free = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_free.
  - in_ready = !s1_valid | s1_adv. This is the only combinational path from out_ready to in_ready.
- Output holds: while out_valid=1 and out_ready=0, out_instr and out_err stay stable and the pipeline stalls. S1 and S2 both stay full, no word is lost or duplicated, and in_ready=0.
- Handshake rules:
  - An in_valid with in_ready=0 is not captured; the source must hold it.
  - out_valid never depends combinationally on out_ready.
- Simultaneous events:
  - Accept into S1, S1→S2 advance and output delivery can all happen in the same edge.
  - Ordering is strictly first-in, first-out.
- Counters:
  - Increment on the delivery edge.
  - Saturate at all-ones with no wrap.
  - err_count increments only when the delivered word has out_err=1.

Test Plan:
- ITYPE, imm=32'hFFFF_FFFF, op=7'h13, rd=1, rs1=0, f3=0 → out_instr=32'hFFF0_0093, out_err=0, out_valid 2 cycles after the accept; enc_count=1.
- BTYPE imm=8, op=7'h63, rs1=rs2=0, f3=0 → 32'h0000_0463. JTYPE imm=32'h800, rd=1, op=7'h6F → 32'h0010_00EF. UTYPE imm=32'h1234_5000, rd=5, op=7'h37 → 32'h1234_52B7.
- Errors:
  - ITYPE imm=2048, BTYPE imm=3, UTYPE imm=32'h1 and type=7 → each gives out_instr=32'h0000_0013, out_err=1; err_count=4 after delivery.
  - ITYPE imm=2047 and imm=-2048 → no error.
- Back-to-back stream of 10 words with out_ready held at 1 → one word per cycle, output order matches input order, in_ready stays 1.
- Stall: hold out_ready=0 while pushing 3 words → 2 accepted, then in_ready=0 and out_instr stable. Release out_ready → all 3 words delivered in order, no duplicates, then in_ready returns to 1.
- Reset: assert rst_n=0 with both stages full and counters nonzero → out_valid=0 and counters=0 immediately (asynchronous). After release, the next word is encoded correctly with 2-cycle latency. Counter saturation checked by forcing the count near all-ones.

Source files
------------

// File: rtl/imm_operand_encoder.sv
// rtl/imm_operand_encoder.sv - RV32I instruction packer: immediate range check (S1), word packing (S2)
// Two-stage valid/ready pipeline with saturating delivered-word and error counters.
module imm_operand_encoder #(
   parameter int unsigned CNT_W    = 16,
   parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_type,
   input  logic [31:0]      in_imm,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [2:0] {
      T_R = 3'd0,
      T_I = 3'd1,
      T_S = 3'd2,
      T_B = 3'd3,
      T_U = 3'd4,
      T_J = 3'd5
   } imm_type_e;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             r_s1_valid;
   logic [2:0]       r_s1_type;
   logic [31:0]      r_s1_imm;
   logic [6:0]       r_s1_opcode;
   logic [4:0]       r_s1_rd;
   logic [4:0]       r_s1_rs1;
   logic [4:0]       r_s1_rs2;
   logic [2:0]       r_s1_funct3;
   logic [6:0]       r_s1_funct7;
   logic             r_s1_err;

   logic             r_out_valid;
   logic [31:0]      r_out_instr;
   logic             r_out_err;
   logic [CNT_W-1:0] r_enc_count;
   logic [CNT_W-1:0] r_err_count;

   logic             w_s2_free;
   logic             w_s1_adv;
   logic             w_accept;
   logic             w_deliver;
   logic             w_err;
   logic [31:0]      w_pack;

   assign w_s2_free = !r_out_valid || out_ready;
   assign w_s1_adv  = r_s1_valid && w_s2_free;
   assign in_ready  = !r_s1_valid || w_s1_adv;
   assign w_accept  = in_valid && in_ready;
   assign w_deliver = r_out_valid && out_ready;

   // "All equal" upper bits means the value fits the signed field width.
   always_comb begin
      w_err = 1'b0;
      case (in_type)
         T_R:      w_err = 1'b0;
         T_I, T_S: w_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
         T_B:      w_err = in_imm[0] || !((&in_imm[31:12]) || !(|in_imm[31:12]));
         T_U:      w_err = |in_imm[11:0];
         T_J:      w_err = in_imm[0] || !((&in_imm[31:20]) || !(|in_imm[31:20]));
         default:  w_err = 1'b1;
      endcase
   end

   always_comb begin
      w_pack = 32'h0;
      case (r_s1_type)
         T_R: w_pack = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
         T_I: w_pack = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
         T_S: w_pack = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_imm[4:0],
                        r_s1_opcode};
         T_B: w_pack = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                        r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
         T_U: w_pack = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
         T_J: w_pack = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                        r_s1_rd, r_s1_opcode};
         default: w_pack = NOP_WORD;
      endcase
      if (r_s1_err) begin
         w_pack = NOP_WORD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_type   <= 3'd0;
         r_s1_imm    <= 32'h0;
         r_s1_opcode <= 7'h0;
         r_s1_rd     <= 5'h0;
         r_s1_rs1    <= 5'h0;
         r_s1_rs2    <= 5'h0;
         r_s1_funct3 <= 3'h0;
         r_s1_funct7 <= 7'h0;
         r_s1_err    <= 1'b0;
      end else if (w_accept) begin
         r_s1_valid  <= 1'b1;
         r_s1_type   <= in_type;
         r_s1_imm    <= in_imm;
         r_s1_opcode <= in_opcode;
         r_s1_rd     <= in_rd;
         r_s1_rs1    <= in_rs1;
         r_s1_rs2    <= in_rs2;
         r_s1_funct3 <= in_funct3;
         r_s1_funct7 <= in_funct7;
         r_s1_err    <= w_err;
      end else if (w_s1_adv) begin
         r_s1_valid  <= 1'b0;
      end
   end

   // out_instr/out_err only change when a new word advances, so they hold during a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_instr <= 32'h0;
         r_out_err   <= 1'b0;
      end else if (w_s1_adv) begin
         r_out_valid <= 1'b1;
         r_out_instr <= w_pack;
         r_out_err   <= r_s1_err;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enc_count <= '0;
         r_err_count <= '0;
      end else if (w_deliver) begin
         if (r_enc_count != CNT_MAX) begin
            r_enc_count <= r_enc_count + CNT_ONE;
         end
         if (r_out_err && (r_err_count != CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_ONE;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_err   = r_out_err;
   assign enc_count = r_enc_count;
   assign err_count = r_err_count;

endmodule
